// File: rtl/addressdecode_cfg_seq_if.sv
// Host write channel into the address-decode config sequencer.
interface addressdecode_cfg_seq_if;
    logic       host_valid;
    logic       host_ready;
    logic [7:0] host_addr;
    logic [7:0] host_wdata;
    logic       host_clear;

    modport master (
        output host_valid, host_addr, host_wdata, host_clear,
        input  host_ready
    );

    modport slave (
        input  host_valid, host_addr, host_wdata, host_clear,
        output host_ready
    );
endinterface

// File: rtl/addressdecode_cfg_seq.sv
// Sole driver of the decode-table byte write port: boot ROM load, host writes, clear sweep.
// Boot load from ROM is present only when ADDRDEC_CFG_INIT_EN is defined.
module addressdecode_cfg_seq #(
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned NUM_WIN  = 16,
    parameter int unsigned INIT_LEN = 160
) (
    input  logic                   cfg_clk,
    input  logic                   cfg_rst_n,
    output logic [7:0]             rom_addr,
    input  logic [7:0]             rom_data,
    addressdecode_cfg_seq_if.slave host,
    output logic                   cfg_we,
    output logic [7:0]             cfg_addr,
    output logic [7:0]             cfg_wdata,
    output logic                   busy,
    output logic                   init_done,
    output logic                   err
);

    localparam int unsigned CFG_BYTES = (ADDR_W + 7) / 8;
    localparam int unsigned TOTAL     = NUM_WIN * (2 * CFG_BYTES + 2);
    localparam int unsigned OP_OFF    = 2 * NUM_WIN * CFG_BYTES + NUM_WIN;
    localparam int unsigned CNT_W     = 9;

    localparam logic [CNT_W-1:0] TOTAL_C  = CNT_W'(TOTAL);
    localparam logic [CNT_W-1:0] OP_OFF_C = CNT_W'(OP_OFF);

    if (TOTAL > 256) begin : g_chk_total
        $error("addressdecode_cfg_seq: table layout exceeds 256 bytes");
    end
    if (INIT_LEN > TOTAL) begin : g_chk_init_len
        $error("addressdecode_cfg_seq: INIT_LEN larger than the table");
    end

    typedef enum logic [1:0] {ST_INIT, ST_HOST, ST_CLEAR} state_t;

`ifdef ADDRDEC_CFG_INIT_EN
    localparam logic [CNT_W-1:0] INIT_LEN_C = CNT_W'(INIT_LEN);
    localparam state_t RST_STATE = (INIT_LEN == 0) ? ST_HOST : ST_INIT;
    localparam logic   RST_BUSY  = (INIT_LEN != 0);
`else
    localparam state_t RST_STATE = ST_HOST;
    localparam logic   RST_BUSY  = 1'b0;
`endif

    // Power-on default byte for a table offset: OP fields are 0xFF, everything else 0.
    function automatic logic [7:0] clr_byte(input logic [CNT_W-1:0] j);
        return (j >= OP_OFF_C) ? 8'hFF : 8'h00;
    endfunction

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       rom_addr_d, addr_d, wdata_q, wdata_d;
    logic             we_d, fwd_q, fwd_d, busy_d, init_done_d, err_d;
    logic             clr_pend_q, clr_pend_d, start_clr;

    assign host.host_ready = (state_q == ST_HOST) && !host.host_clear;

    // rom_data is already a ROM flop output; forwarding it keeps each boot write one cycle after its rom_addr.
    assign cfg_wdata = fwd_q ? rom_data : wdata_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rom_addr_d  = rom_addr;
        we_d        = 1'b0;
        addr_d      = cfg_addr;
        wdata_d     = wdata_q;
        fwd_d       = 1'b0;
        busy_d      = busy;
        init_done_d = init_done;
        err_d       = err;
        clr_pend_d  = clr_pend_q;
        start_clr   = 1'b0;

        unique case (state_q)
`ifdef ADDRDEC_CFG_INIT_EN
            ST_INIT: begin
                if (host.host_clear) begin
                    clr_pend_d = 1'b1;
                end
                if (cnt_q < INIT_LEN_C) begin
                    we_d       = 1'b1;
                    addr_d     = cnt_q[7:0];
                    fwd_d      = 1'b1;
                    cnt_d      = cnt_q + CNT_W'(1);
                    rom_addr_d = 8'(cnt_q + CNT_W'(1));
                end else begin
                    init_done_d = 1'b1;
                    rom_addr_d  = '0;
                    if (clr_pend_q || host.host_clear) begin
                        start_clr = 1'b1;
                    end else begin
                        state_d = ST_HOST;
                        busy_d  = 1'b0;
                    end
                end
            end
`endif
            ST_HOST: begin
                init_done_d = 1'b1;
                if (host.host_clear) begin
                    start_clr = 1'b1;
                end else if (host.host_valid) begin
                    if ({1'b0, host.host_addr} < TOTAL_C) begin
                        we_d    = 1'b1;
                        addr_d  = host.host_addr;
                        wdata_d = host.host_wdata;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_CLEAR: begin
                if (cnt_q < TOTAL_C) begin
                    we_d    = 1'b1;
                    addr_d  = cnt_q[7:0];
                    wdata_d = clr_byte(cnt_q);
                    cnt_d   = cnt_q + CNT_W'(1);
                end else begin
                    state_d = ST_HOST;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d = RST_STATE;
            end
        endcase

        // Byte 0 of the sweep issues on the entry edge so the sweep spans exactly TOTAL busy cycles.
        if (start_clr) begin
            state_d    = ST_CLEAR;
            busy_d     = 1'b1;
            clr_pend_d = 1'b0;
            err_d      = 1'b0;
            we_d       = 1'b1;
            addr_d     = '0;
            wdata_d    = clr_byte('0);
            cnt_d      = CNT_W'(1);
        end
    end

    always_ff @(posedge cfg_clk or negedge cfg_rst_n) begin
        if (!cfg_rst_n) begin
            state_q    <= RST_STATE;
            cnt_q      <= '0;
            rom_addr   <= '0;
            cfg_we     <= 1'b0;
            cfg_addr   <= '0;
            wdata_q    <= '0;
            fwd_q      <= 1'b0;
            busy       <= RST_BUSY;
            init_done  <= 1'b0;
            err        <= 1'b0;
            clr_pend_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rom_addr   <= rom_addr_d;
            cfg_we     <= we_d;
            cfg_addr   <= addr_d;
            wdata_q    <= wdata_d;
            fwd_q      <= fwd_d;
            busy       <= busy_d;
            init_done  <= init_done_d;
            err        <= err_d;
            clr_pend_q <= clr_pend_d;
        end
    end

endmodule
